// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall generation for the REG/DEC stage.
// Keeps shadow EX/MEM destination slots and a saturating stall counter.
module forward_hazard_unit #(
   parameter int unsigned REG_BITS = 5,
   parameter int unsigned ZERO_REG = 31,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      OPCodeIn,
   input  logic             Reg2Loc,
   input  logic             UsesA,
   input  logic             UsesB,
   input  logic             RegWriteIn,
   input  logic             Mem2RegIn,
   input  logic             NOOPIn,
   input  logic             flush,
   output logic [1:0]       ForwardMuxA,
   output logic [1:0]       ForwardMuxB,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned RD_LSB = 0;
   localparam int unsigned RN_LSB = 5;
   localparam int unsigned RM_LSB = 16;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   typedef enum logic {RUN, STALL} state_t;

   state_t              state_q;
   logic                ex_v_q, ex_wr_q, ex_ld_q;
   logic [REG_BITS-1:0] ex_rd_q;
   logic                mem_v_q, mem_wr_q;
   logic [REG_BITS-1:0] mem_rd_q;
   logic [CNT_W-1:0]    stall_count_q;

   logic                ex_v_d, ex_wr_d, ex_ld_d;
   logic [REG_BITS-1:0] ex_rd_d;
   logic [REG_BITS-1:0] src_a, src_b, dst;
   logic                ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic                load_use;
   logic [1:0]          sel_a, sel_b;
   logic                unused_opcode;

   assign unused_opcode = ^OPCodeIn;

   function automatic logic hit(input logic v, input logic wr,
                                input logic [REG_BITS-1:0] rd,
                                input logic [REG_BITS-1:0] src,
                                input logic uses);
      return v & wr & uses & (rd == src) & (src != REG_BITS'(ZERO_REG));
   endfunction

   // A stalling load in EX suppresses forwarding for that operand; EX beats MEM.
   function automatic logic [1:0] pick(input logic ex_hit, input logic ex_ld,
                                       input logic mem_hit);
      if (ex_hit)       return ex_ld ? SEL_RF : SEL_EX;
      else if (mem_hit) return SEL_MEM;
      else              return SEL_RF;
   endfunction

   always_comb begin
      dst       = OPCodeIn[RD_LSB +: REG_BITS];
      src_a     = OPCodeIn[RN_LSB +: REG_BITS];
      src_b     = Reg2Loc ? OPCodeIn[RM_LSB +: REG_BITS] : dst;
      ex_hit_a  = hit(ex_v_q, ex_wr_q, ex_rd_q, src_a, UsesA);
      ex_hit_b  = hit(ex_v_q, ex_wr_q, ex_rd_q, src_b, UsesB);
      mem_hit_a = hit(mem_v_q, mem_wr_q, mem_rd_q, src_a, UsesA);
      mem_hit_b = hit(mem_v_q, mem_wr_q, mem_rd_q, src_b, UsesB);
      load_use  = ex_ld_q & (ex_hit_a | ex_hit_b);
      sel_a     = pick(ex_hit_a, ex_ld_q, mem_hit_a);
      sel_b     = pick(ex_hit_b, ex_ld_q, mem_hit_b);
   end

   // Outputs are held quiet while reset is asserted; flush overrides load-use.
   always_comb begin
      ForwardMuxA = SEL_RF;
      ForwardMuxB = SEL_RF;
      stall       = 1'b0;
      bubble      = 1'b0;
      if (!reset) begin
         ForwardMuxA = sel_a;
         ForwardMuxB = sel_b;
         stall       = load_use & ~flush;
         bubble      = load_use | flush;
      end
   end

   always_comb begin
      ex_v_d  = 1'b0;
      ex_rd_d = '0;
      ex_wr_d = 1'b0;
      ex_ld_d = 1'b0;
      if (!bubble) begin
         ex_v_d  = 1'b1;
         ex_rd_d = dst;
         ex_wr_d = RegWriteIn & ~NOOPIn;
         ex_ld_d = Mem2RegIn & ~NOOPIn;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_v_q        <= 1'b0;
         ex_rd_q       <= '0;
         ex_wr_q       <= 1'b0;
         ex_ld_q       <= 1'b0;
         mem_v_q       <= 1'b0;
         mem_rd_q      <= '0;
         mem_wr_q      <= 1'b0;
         stall_count_q <= '0;
      end else begin
         mem_v_q  <= ex_v_q;
         mem_rd_q <= ex_rd_q;
         mem_wr_q <= ex_wr_q;
         ex_v_q   <= ex_v_d;
         ex_rd_q  <= ex_rd_d;
         ex_wr_q  <= ex_wr_d;
         ex_ld_q  <= ex_ld_d;
         if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_q <= stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         case (state_q)
            RUN:     state_q <= stall ? STALL : RUN;
            STALL:   state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign stall_count = stall_count_q;

   // EX holds a bubble in STALL, so a load-use hit there means back-to-back stalls.
   a_no_double_stall: assert property (@(posedge clk) disable iff (reset)
      (state_q == STALL) |-> !load_use);

endmodule
